traffic_sensor_conditioner: RTL and testbench

- Upstream stage of the intersection controller; drives its 2-bit traffic-level inputs Sa..Sd.
- Takes four raw vehicle-detector lines (lanes A-D), then synchronises, debounces and edge-detects each one.
- Counts vehicles per lane over a window of WINDOW_TICKS sample ticks and quantises each count to a 2-bit level.
- Levels update only at window boundaries, so controller comparisons stay stable; falling levels decay one step per window.

---
 rtl/traffic_sensor_conditioner.sv | 139 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Conditions four raw vehicle-detector lines into 2-bit per-lane traffic levels.
// Each lane is synchronised, debounced and edge-detected, and its events are counted over a tick window.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WINDOW_TICKS = 10,
  parameter int CNT_W        = 6,
  parameter int TH1          = 2,
  parameter int TH2          = 5,
  parameter int TH3          = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       det_c,
  input  logic       det_d,
  output logic [1:0] Sa,
  output logic [1:0] Sb,
  output logic [1:0] Sc,
  output logic [1:0] Sd,
  output logic       window_done,
  output logic [3:0] sat_flags
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]            det;
  logic [3:0]            sync1;
  logic [3:0]            sync2;
  logic [3:0]            filt;
  logic [3:0]            ev;
  logic [3:0]            pend_sat;
  logic [3:0]            sat_hit;
  logic [3:0][DEB_W-1:0] deb_cnt;
  logic [3:0][CNT_W-1:0] cnt;
  logic [3:0][CNT_W-1:0] cnt_eff;
  logic [3:0][1:0]       raw_lvl;
  logic [3:0][1:0]       lvl;
  logic [WIN_W-1:0]      win_cnt;
  logic                  win_end;

  assign det = {det_d, det_c, det_b, det_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= det;
      sync2 <= sync1;
    end
  end

  // The filtered value only follows the synchronised line after DEBOUNCE_CYC
  // consecutive disagreeing clocks; ev pulses for one cycle on a filtered rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= '0;
      ev      <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
          filt[i]    <= ~filt[i];
          deb_cnt[i] <= '0;
          ev[i]      <= ~filt[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign win_end = tick && (win_cnt == WIN_W'(WINDOW_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (tick) begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
    end
  end

  // An event landing on the window-end cycle still belongs to the closing window.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sat_hit[i] = ev[i] && (cnt[i] == CNT_MAX);
      cnt_eff[i] = (ev[i] && (cnt[i] != CNT_MAX)) ? cnt[i] + 1'b1 : cnt[i];
      if (cnt_eff[i] < CNT_W'(TH1))      raw_lvl[i] = 2'd0;
      else if (cnt_eff[i] < CNT_W'(TH2)) raw_lvl[i] = 2'd1;
      else if (cnt_eff[i] < CNT_W'(TH3)) raw_lvl[i] = 2'd2;
      else                               raw_lvl[i] = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pend_sat <= '0;
    end else if (win_end) begin
      cnt      <= '0;
      pend_sat <= '0;
    end else begin
      cnt      <= cnt_eff;
      pend_sat <= pend_sat | sat_hit;
    end
  end

  // window_done is a single-cycle strobe (no ready/backpressure): it is high
  // exactly in the cycle the new levels and sat_flags first appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl         <= '0;
      sat_flags   <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= win_end;
      if (win_end) begin
        sat_flags <= pend_sat | sat_hit;
        for (int i = 0; i < 4; i++) begin
          // raw < lvl implies lvl >= 1, so the decay never wraps
          lvl[i] <= (raw_lvl[i] >= lvl[i]) ? raw_lvl[i] : lvl[i] - 2'd1;
        end
      end
    end
  end

  assign Sa = lvl[0];
  assign Sb = lvl[1];
  assign Sc = lvl[2];
  assign Sd = lvl[3];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: stimulus pushes expected
// window results into a queue, a monitor pops them on every window_done.
module tb_traffic_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] det;
  logic [1:0] Sa, Sb, Sc, Sd;
  logic       window_done;
  logic [3:0] sat_flags;

  // {sat_flags, Sd, Sc, Sb, Sa}
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_wd = 1'b0;

  traffic_sensor_conditioner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .det_a       (det[0]),
    .det_b       (det[1]),
    .det_c       (det[2]),
    .det_d       (det[3]),
    .Sa          (Sa),
    .Sb          (Sb),
    .Sc          (Sc),
    .Sd          (Sd),
    .window_done (window_done),
    .sat_flags   (sat_flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic pulse(input logic [3:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      det = mask;
      wait_clk(8);
      det = 4'b0000;
      wait_clk(8);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      wait_clk(1);
      tick = 1'b0;
      wait_clk(1);
    end
  endtask

  task automatic push_exp(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] sc,
                          input logic [1:0] sd, input logic [3:0] sat);
    exp_q.push_back({sat, sd, sc, sb, sa});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_Sa"}, 32'(Sa), 0);
    check({tag, "_Sb"}, 32'(Sb), 0);
    check({tag, "_Sc"}, 32'(Sc), 0);
    check({tag, "_Sd"}, 32'(Sd), 0);
    check({tag, "_wd"}, 32'(window_done), 0);
    check({tag, "_sat"}, 32'(sat_flags), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && window_done) begin
      logic [11:0] e;
      check("wd_single_cycle", 32'(prev_wd), 0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window_done: got window_done=1 expected no window end");
      end else begin
        e = exp_q.pop_front();
        check("Sa", 32'(Sa), 32'(e[1:0]));
        check("Sb", 32'(Sb), 32'(e[3:2]));
        check("Sc", 32'(Sc), 32'(e[5:4]));
        check("Sd", 32'(Sd), 32'(e[7:6]));
        check("sat_flags", 32'(sat_flags), 32'(e[11:8]));
      end
    end
    prev_wd = window_done;
  end

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    det   = 4'b0000;
    wait_clk(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(2);

    // 6 pulses on lane B
    pulse(4'b0010, 6);
    push_exp(0, 2, 0, 0, 0);
    ticks(10);
    wait_clk(2);

    // reset mid-window with detector lines toggling
    pulse(4'b0001, 3);
    ticks(5);
    det = 4'b0101;
    wait_clk(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    det = 4'b1010;
    wait_clk(2);
    det = 4'b0111;
    wait_clk(2);
    check_all_zero("held_reset");
    det = 4'b0000;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(3);

    // first window after reset: one event only, tick count restarts at 0
    pulse(4'b0001, 1);
    push_exp(0, 0, 0, 0, 0);
    ticks(9);
    check("no_early_window", 32'(exp_q.size()), 1);
    ticks(1);
    wait_clk(2);

    // glitches shorter than the debounce time plus one clean pulse
    for (int k = 0; k < 3; k++) begin
      det = 4'b0001;
      wait_clk(3);
      det = 4'b0000;
      wait_clk(8);
    end
    pulse(4'b0001, 1);
    push_exp(0, 0, 0, 0, 0);
    ticks(10);
    wait_clk(2);

    // two clean pulses reach TH1
    pulse(4'b0001, 2);
    push_exp(1, 0, 0, 0, 0);
    ticks(10);
    wait_clk(2);

    // decay on lane C
    pulse(4'b0100, 12);
    push_exp(0, 0, 3, 0, 0);
    ticks(10);
    push_exp(0, 0, 2, 0, 0);
    ticks(10);
    push_exp(0, 0, 1, 0, 0);
    ticks(10);
    push_exp(0, 0, 0, 0, 0);
    ticks(10);
    push_exp(0, 0, 0, 0, 0);
    ticks(10);
    pulse(4'b0100, 6);
    push_exp(0, 0, 2, 0, 0);
    ticks(10);
    wait_clk(2);

    // simultaneous lanes: a=9, b=5, c=2, d=2
    pulse(4'b1111, 2);
    pulse(4'b0011, 3);
    pulse(4'b0001, 4);
    push_exp(3, 2, 1, 1, 0);
    ticks(10);
    wait_clk(2);

    // saturation on lane D
    pulse(4'b1000, 70);
    push_exp(2, 1, 0, 3, 4'b1000);
    ticks(10);
    wait_clk(2);
    pulse(4'b1000, 3);
    push_exp(1, 0, 0, 2, 0);
    ticks(10);
    wait_clk(2);

    // no tick: levels hold
    wait_clk(40);
    check("hold_Sa", 32'(Sa), 1);
    check("hold_Sd", 32'(Sd), 2);
    check("hold_sat", 32'(sat_flags), 0);

    // event coincident with the closing tick counts in the closing window
    pulse(4'b0001, 1);
    push_exp(1, 0, 0, 1, 0);
    ticks(9);
    det = 4'b0001;
    wait_clk(6);
    tick = 1'b1;
    wait_clk(1);
    tick = 1'b0;
    wait_clk(1);
    det = 4'b0000;
    wait_clk(8);

    // next window starts from zero; tick held high for ten cycles
    pulse(4'b0001, 1);
    push_exp(0, 0, 0, 0, 0);
    tick = 1'b1;
    wait_clk(10);
    tick = 1'b0;
    wait_clk(2);

    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      wait_clk(1);
    end
    check("queue_drained", 32'(exp_q.size()), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
